floor_tracker: RTL

//  Parametrised elevator floor-position tracker for NUM_FLOORS floors. Takes
//  one-hot floor-sensor vector, debounces it, accepts only legal moves, and

---
 rtl/floor_tracker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/floor_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : floor_tracker
//  Description : Debounced elevator floor tracker with move legality check,
//                last-direction memory, arrival pulse and sticky fault flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module floor_tracker #(
    parameter int NUM_FLOORS  = 4,
    parameter int DEBOUNCE    = 3,
    parameter int RESET_FLOOR = 0,
    parameter int STRICT_ADJ  = 1,
    localparam int FLOOR_W    = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] sensors,
    input  logic                  clr_fault,
    output logic [FLOOR_W-1:0]    floor,
    output logic [1:0]            dir,
    output logic                  arrived,
    output logic                  fault
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] S_TRACK    = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_FAULT    = 2'd2;

    localparam logic [1:0] c_dir_none = 2'b00;
    localparam logic [1:0] c_dir_up   = 2'b01;
    localparam logic [1:0] c_dir_down = 2'b10;

    localparam logic [NUM_FLOORS-1:0] c_sens_one  = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      c_cnt_db    = CNT_W'(DEBOUNCE);
    localparam logic [FLOOR_W:0]      c_ext_one   = {{FLOOR_W{1'b0}}, 1'b1};
    localparam logic [FLOOR_W-1:0]    c_rst_floor = FLOOR_W'(RESET_FLOOR);
    localparam logic                  c_single    = (DEBOUNCE == 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [FLOOR_W-1:0] r_cand;
    logic               r_cand_multi;
    logic [FLOOR_W-1:0] r_floor;
    logic [1:0]         r_dir;
    logic               r_arrived;
    logic               r_fault;

    logic               w_zero;
    logic               w_multi;
    logic               w_onehot;
    logic [FLOOR_W-1:0] w_idx;
    logic               w_new_cand;
    logic               w_match;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_decide;
    logic [FLOOR_W-1:0] w_dec_idx;
    logic               w_dec_multi;
    logic [FLOOR_W:0]   w_dec_ext;
    logic [FLOOR_W:0]   w_floor_ext;
    logic               w_adjacent;
    logic               w_legal;

    // Sample classification: clearing the lowest set bit leaves anything only
    // when two or more sensors are active.
    assign w_zero   = (sensors == '0);
    assign w_multi  = |(sensors & (sensors - c_sens_one));
    assign w_onehot = !w_zero && !w_multi;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (sensors[i]) begin
                w_idx = FLOOR_W'(i);
            end
        end
    end

    assign w_new_cand = !w_zero && !(w_onehot && (w_idx == r_floor));
    assign w_match    = r_cand_multi ? w_multi
                                     : (w_onehot && (w_idx == r_cand));
    assign w_cnt_inc  = (r_cnt == c_cnt_db) ? r_cnt : (r_cnt + c_cnt_one);

    // The decision uses the live sample when it is taken straight from TRACK.
    assign w_decide    = ((r_state == S_TRACK) && w_new_cand && c_single) ||
                         ((r_state == S_DEBOUNCE) && w_match && (w_cnt_inc == c_cnt_db));
    assign w_dec_idx   = (r_state == S_TRACK) ? w_idx   : r_cand;
    assign w_dec_multi = (r_state == S_TRACK) ? w_multi : r_cand_multi;

    // Extra bit keeps top-floor + 1 from wrapping onto floor 0.
    assign w_dec_ext   = {1'b0, w_dec_idx};
    assign w_floor_ext = {1'b0, r_floor};
    assign w_adjacent  = (w_dec_ext == (w_floor_ext + c_ext_one)) ||
                         (w_floor_ext == (w_dec_ext + c_ext_one));

    generate
        if (STRICT_ADJ != 0) begin : g_strict_adj
            assign w_legal = w_adjacent;
        end else begin : g_any_floor
            assign w_legal = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_TRACK;
            r_cnt        <= '0;
            r_cand       <= '0;
            r_cand_multi <= 1'b0;
            r_floor      <= c_rst_floor;
            r_dir        <= c_dir_none;
            r_arrived    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_arrived <= 1'b0;
            if (w_decide) begin
                r_cnt        <= '0;
                r_cand       <= '0;
                r_cand_multi <= 1'b0;
                if (w_dec_multi || !w_legal) begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end else begin
                    r_state   <= S_TRACK;
                    r_floor   <= w_dec_idx;
                    r_dir     <= (w_dec_idx > r_floor) ? c_dir_up : c_dir_down;
                    r_arrived <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_TRACK: begin
                        if (w_new_cand) begin
                            r_cand       <= w_idx;
                            r_cand_multi <= w_multi;
                            r_cnt        <= c_cnt_one;
                            r_state      <= S_DEBOUNCE;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (w_match) begin
                            r_cnt <= w_cnt_inc;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_TRACK;
                        end
                    end
                    S_FAULT: begin
                        if (clr_fault) begin
                            r_state <= S_TRACK;
                            r_fault <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_TRACK;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign floor   = r_floor;
    assign dir     = r_dir;
    assign arrived = r_arrived;
    assign fault   = r_fault;

endmodule
`default_nettype wire
